// File: rtl/approx_eval_pkg.sv
// rtl/approx_eval_pkg.sv - shared types, constants and helpers for approximate-adder evaluation
// Purpose: sweep FSM state encoding, default operand width, vector count,
// "no failure recorded" marker and an unsigned absolute-difference helper.
// The top-level N parameter defaults to APX_N; FAIL_NONE and NVEC describe that default width.
package approx_eval_pkg;

    localparam int APX_N = 3;
    localparam int NVEC = 2 ** (2 * APX_N);
    localparam logic [2*APX_N-1:0] FAIL_NONE = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Unsigned |x - y| without wrap; callers zero-extend into and truncate out of 16 bits.
    function automatic logic [15:0] abs_diff(input logic [15:0] x, input logic [15:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_adder_err_sweep_err_accum.sv
// rtl/approx_adder_err_sweep_err_accum.sv - stage-2 error accumulators (max, count, first fail)
// Ports: clk, rst (async, active-high); clear restarts the accumulators for a new sweep;
// en applies one stage-1 entry (in_v, in_exact, in_sum);
// max_err / err_count / first_fail are the registered accumulator values.
import approx_eval_pkg::*;

module err_accum #(
    parameter int N  = APX_N,
    parameter int ET = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [2*N-1:0]   in_v,
    input  logic [N:0]       in_exact,
    input  logic [N:0]       in_sum,
    output logic [N:0]       max_err,
    output logic [2*N:0]     err_count,
    output logic [2*N-1:0]   first_fail
);

    localparam int EW = N + 1;
    localparam int CW = 2 * N + 1;
    localparam logic [N:0] ET_V = EW'(ET);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [N:0]     err;
    logic [N:0]     max_err_q, max_err_d;
    logic [CW-1:0]  err_count_q, err_count_d;
    logic [2*N-1:0] first_fail_q, first_fail_d;

    assign err = EW'(abs_diff(16'(in_exact), 16'(in_sum)));

    always_comb begin
        max_err_d    = max_err_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        if (clear) begin
            max_err_d    = '0;
            err_count_d  = '0;
            first_fail_d = '1;
        end else if (en) begin
            if (err > max_err_q) begin
                max_err_d = err;
            end
            if (err != '0) begin
                err_count_d = err_count_q + CNT_ONE;
            end
            // Only the earliest offending vector is kept; all-ones marks an empty record.
            if ((err > ET_V) && (first_fail_q == '1)) begin
                first_fail_d = in_v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_err_q    <= '0;
            err_count_q  <= '0;
            first_fail_q <= '1;
        end else begin
            max_err_q    <= max_err_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign max_err    = max_err_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: rtl/approx_adder_err_sweep.sv
// rtl/approx_adder_err_sweep.sv - exhaustive error-sweep controller for an approximate adder
// Ports: clk, rst (async, active-high); start / abort requests;
// apx_a, apx_b, apx_valid drive the adder under test, apx_sum is its same-cycle response;
// busy, done, pass status; max_err, err_count, first_fail sweep results.
import approx_eval_pkg::*;

module approx_adder_err_sweep #(
    parameter int N  = APX_N,
    parameter int ET = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [N-1:0]     apx_a,
    output logic [N-1:0]     apx_b,
    output logic             apx_valid,
    input  logic [N:0]       apx_sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N:0]       max_err,
    output logic [2*N:0]     err_count,
    output logic [2*N-1:0]   first_fail
);

    localparam int VW = 2 * N;
    localparam int EW = N + 1;
    localparam logic [VW-1:0] V_LAST = '1;
    localparam logic [VW-1:0] V_ONE  = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [N:0]    ET_V   = EW'(ET);

    state_t         state_q, state_d;
    logic [VW-1:0]  v_q, v_d;
    logic           aborted_q, aborted_d;
    logic           s1_valid_q, s1_valid_d;
    logic [VW-1:0]  s1_v_q, s1_v_d;
    logic [N:0]     s1_exact_q, s1_exact_d;
    logic [N:0]     s1_sum_q, s1_sum_d;
    logic [N:0]     exact;
    logic           start_ok;
    logic           abort_ok;

    // Operands come straight from the vector register, so they hold whenever v_q holds.
    assign apx_a     = v_q[N-1:0];
    assign apx_b     = v_q[VW-1:N];
    assign apx_valid = (state_q == ST_SWEEP);
    assign exact     = {1'b0, apx_a} + {1'b0, apx_b};

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign abort_ok = abort && ((state_q == ST_SWEEP) || (state_q == ST_DRAIN));

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        aborted_d  = aborted_q;
        // An accepted abort squashes whatever would enter stage 1 this edge.
        s1_valid_d = apx_valid && !abort_ok;
        s1_v_d     = s1_v_q;
        s1_exact_d = s1_exact_q;
        s1_sum_d   = s1_sum_q;
        if (apx_valid) begin
            s1_v_d     = v_q;
            s1_exact_d = exact;
            s1_sum_d   = apx_sum;
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d   = ST_SWEEP;
                    v_d       = '0;
                    aborted_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (abort_ok) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (v_q == V_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    v_d = v_q + V_ONE;
                end
            end
            ST_DRAIN: begin
                // Stage 1 holds the last vector; it retires on this edge, emptying the pipe.
                state_d = ST_DONE;
                if (abort_ok) begin
                    aborted_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            v_q        <= '0;
            aborted_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_v_q     <= '0;
            s1_exact_q <= '0;
            s1_sum_q   <= '0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            aborted_q  <= aborted_d;
            s1_valid_q <= s1_valid_d;
            s1_v_q     <= s1_v_d;
            s1_exact_q <= s1_exact_d;
            s1_sum_q   <= s1_sum_d;
        end
    end

    err_accum #(
        .N  (N),
        .ET (ET)
    ) u_err_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .en         (s1_valid_q && !abort_ok),
        .in_v       (s1_v_q),
        .in_exact   (s1_exact_q),
        .in_sum     (s1_sum_q),
        .max_err    (max_err),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    assign busy = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);
    assign pass = done && !aborted_q && (max_err <= ET_V);

endmodule

// File: tb/tb_approx_adder_err_sweep.sv
// tb/tb_approx_adder_err_sweep.sv - directed self-checking bench for approx_adder_err_sweep
module tb_approx_adder_err_sweep;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] apx_a;
    logic [2:0] apx_b;
    logic       apx_valid;
    logic [3:0] apx_sum;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] max_err;
    logic [6:0] err_count;
    logic [5:0] first_fail;

    logic [1:0] mode;   // 0 exact, 1 stuck at zero, 2 exact plus one
    int n_cmp = 0;
    int n_fail = 0;
    int cycles;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            2'd0:    apx_sum = {1'b0, apx_a} + {1'b0, apx_b};
            2'd1:    apx_sum = 4'd0;
            2'd2:    apx_sum = {1'b0, apx_a} + {1'b0, apx_b} + 4'd1;
            default: apx_sum = 4'd0;
        endcase
    end

    approx_adder_err_sweep #(.N(3), .ET(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .apx_a      (apx_a),
        .apx_b      (apx_b),
        .apx_valid  (apx_valid),
        .apx_sum    (apx_sum),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .max_err    (max_err),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    // Returns at the falling edge after the accepting edge E0.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts falling edges after E0 until done; cycle n is sampled after E(n).
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, pass, apx_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, apx_valid}); end
        n_cmp++; if ({max_err, err_count, apx_a, apx_b} !== 17'd0) begin n_fail++; $display("FAIL reset_values: got %h want 0", {max_err, err_count, apx_a, apx_b}); end
        n_cmp++; if (first_fail !== 6'h3F) begin n_fail++; $display("FAIL reset_first_fail: got %h want 3f", first_fail); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exact();
        mode = 2'd0;
        pulse_start();
        n_cmp++; if ({busy, apx_valid, apx_a, apx_b} !== 8'b11_000_000) begin n_fail++; $display("FAIL exact_first_vector: got %b want 11000000", {busy, apx_valid, apx_a, apx_b}); end
        wait_done(200, cycles);
        n_cmp++; if (cycles !== 65) begin n_fail++; $display("FAIL exact_latency: got %0d want 65", cycles); end
        n_cmp++; if ({busy, apx_valid, pass} !== 3'b001) begin n_fail++; $display("FAIL exact_flags: got %b want 001", {busy, apx_valid, pass}); end
        n_cmp++; if ({max_err, err_count} !== 11'd0) begin n_fail++; $display("FAIL exact_counts: got %0d/%0d want 0/0", max_err, err_count); end
        n_cmp++; if (first_fail !== 6'h3F) begin n_fail++; $display("FAIL exact_first_fail: got %h want 3f", first_fail); end
    endtask

    task automatic test_stuck_zero();
        mode = 2'd1;
        pulse_start();
        wait_done(200, cycles);
        n_cmp++; if (cycles !== 65) begin n_fail++; $display("FAIL stuck_latency: got %0d want 65", cycles); end
        n_cmp++; if (max_err !== 4'd14) begin n_fail++; $display("FAIL stuck_max_err: got %0d want 14", max_err); end
        n_cmp++; if (err_count !== 7'd63) begin n_fail++; $display("FAIL stuck_err_count: got %0d want 63", err_count); end
        n_cmp++; if (first_fail !== 6'd5) begin n_fail++; $display("FAIL stuck_first_fail: got %0d want 5", first_fail); end
        n_cmp++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL stuck_pass: got %b want 10", {done, pass}); end
    endtask

    task automatic test_plus_one();
        mode = 2'd2;
        pulse_start();
        wait_done(200, cycles);
        n_cmp++; if (cycles !== 65) begin n_fail++; $display("FAIL plus1_latency: got %0d want 65", cycles); end
        n_cmp++; if (max_err !== 4'd1) begin n_fail++; $display("FAIL plus1_max_err: got %0d want 1", max_err); end
        n_cmp++; if (err_count !== 7'd64) begin n_fail++; $display("FAIL plus1_err_count: got %0d want 64", err_count); end
        n_cmp++; if (first_fail !== 6'h3F) begin n_fail++; $display("FAIL plus1_first_fail: got %h want 3f", first_fail); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL plus1_pass: got %b want 1", pass); end
    endtask

    task automatic test_abort();
        mode = 2'd1;
        pulse_start();
        repeat (20) @(negedge clk);
        n_cmp++; if ({apx_b, apx_a} !== 6'd20) begin n_fail++; $display("FAIL abort_vector: got %0d want 20", {apx_b, apx_a}); end
        // start alongside abort while busy must lose
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_cmp++; if ({done, pass, apx_valid, busy} !== 4'b1000) begin n_fail++; $display("FAIL abort_flags: got %b want 1000", {done, pass, apx_valid, busy}); end
        n_cmp++; if ({max_err, err_count} !== {4'd8, 7'd18}) begin n_fail++; $display("FAIL abort_frozen: got %0d/%0d want 8/18", max_err, err_count); end
        @(negedge clk);
        n_cmp++; if ({done, err_count} !== {1'b1, 7'd18}) begin n_fail++; $display("FAIL abort_hold: got %b/%0d want 1/18", done, err_count); end
        mode = 2'd0;
        pulse_start();
        wait_done(200, cycles);
        n_cmp++; if (cycles !== 65) begin n_fail++; $display("FAIL abort_resweep_latency: got %0d want 65", cycles); end
        n_cmp++; if ({pass, max_err, err_count, first_fail} !== {1'b1, 4'd0, 7'd0, 6'h3F}) begin n_fail++; $display("FAIL abort_resweep_result: got %b/%0d/%0d/%h want 1/0/0/3f", pass, max_err, err_count, first_fail); end
    endtask

    task automatic test_reset_mid_sweep();
        mode = 2'd1;
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({busy, apx_b, apx_a} !== {1'b1, 6'd11}) begin n_fail++; $display("FAIL busy_start_ignored: got %b/%0d want 1/11", busy, {apx_b, apx_a}); end
        n_cmp++; if (err_count !== 7'd9) begin n_fail++; $display("FAIL mid_err_count: got %0d want 9", err_count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy, done, pass, apx_valid, max_err, err_count, apx_a, apx_b} !== 21'd0) begin n_fail++; $display("FAIL async_reset_values: got %h want 0", {busy, done, pass, apx_valid, max_err, err_count, apx_a, apx_b}); end
        n_cmp++; if (first_fail !== 6'h3F) begin n_fail++; $display("FAIL async_reset_first_fail: got %h want 3f", first_fail); end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b want 00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        mode = 2'd1;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            n_cmp++; if ({done, busy, max_err, err_count, first_fail} !== {2'b01, 4'd0, 7'd0, 6'h3F}) begin n_fail++; $display("FAIL b2b_clear_run%0d: got %b%b/%0d/%0d/%h want 01/0/0/3f", r, done, busy, max_err, err_count, first_fail); end
            wait_done(200, cycles);
            n_cmp++; if (cycles !== 65) begin n_fail++; $display("FAIL b2b_latency_run%0d: got %0d want 65", r, cycles); end
            n_cmp++; if ({pass, max_err, err_count, first_fail} !== {1'b0, 4'd14, 7'd63, 6'd5}) begin n_fail++; $display("FAIL b2b_result_run%0d: got %b/%0d/%0d/%0d want 0/14/63/5", r, pass, max_err, err_count, first_fail); end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_stuck_zero();
        test_plus_one();
        test_abort();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
